ahbl_ram_ctrl: RTL and testbench
================================

# ahbl_ram_ctrl

AHB-Lite subordinate that drives one single-port, byte-writable, synchronous-read RAM macro (1-cycle read latency, per-byte write enables, read data held at zero when not enabled). It sits between the N5 AHB-Lite interconnect and the SRAM instance. It converts AHB address/data phases into RAM port cycles: reads complete with zero wait states, writes commit in their data phase, and a read that immediately follows a write costs one wait state.

## Interface
- AW, 12, RAM word-address width (4K words × 32 bits)
- HCLK  in  1  clock; also clocks the RAM
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  subordinate select
- HADDR  in  32  byte address; bits [AW+1:2] index the RAM word
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  000 byte, 001 half, 010 word
- HREADY  in  1  bus-wide ready
- HWDATA  in  32  write data, valid in the data phase
- HREADYOUT  out  1  subordinate ready
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  32  read data
- RAM_EN  out  1  RAM enable
- RAM_WE  out  4  byte write enables; bit n selects bits [8n+7:8n]
- RAM_A  out  AW  RAM word address
- RAM_DI  out  32  RAM write data
- RAM_DO  in  32  RAM read data, registered inside the RAM

## Operation
- Transfer accepted: HSEL & HTRANS[1] & HREADY. BUSY and IDLE are accepted with an OKAY response and no RAM access.
- Byte-lane mask from HSIZE and HADDR[1:0]:
  - byte: 4'b0001 << HADDR[1:0]
  - half: 4'b0011 << {HADDR[1],1'b0}
  - word: 4'b1111
- Write, address phase: register wr_pend=1, wr_addr=HADDR[AW+1:2], wr_mask. The RAM is not touched in this phase.
- Write, data phase (wr_pend=1): RAM_EN=1, RAM_A=wr_addr, RAM_WE=wr_mask, RAM_DI=HWDATA, all combinational. wr_pend clears at the clock edge.
- Read, address phase with no pending write: RAM_EN=1, RAM_WE=0, RAM_A=HADDR[AW+1:2], all combinational. In the next cycle HRDATA=RAM_DO with HREADYOUT=1.
- Collision (a read is accepted while wr_pend=1):
  - The write owns the port and HREADYOUT=0 for one cycle.
  - The master holds the read address phase.
  - In the following cycle, with wr_pend=0, the read issues. It returns the freshly written data when the addresses match.
- Write followed by write: no stall. W1 commits in the same cycle W2's address phase is registered.
- Otherwise RAM_EN=0, RAM_WE=0. RAM_A and RAM_DI are don't-care, but must be driven (no X).
- HRDATA is passed straight from RAM_DO and is valid only in a read data phase.
- Reset (asynchronous, at any time, including mid-transfer):
  - wr_pend=0 and any pending write is dropped.
  - HREADYOUT=1, HRESP=0, RAM_EN=0, RAM_WE=0, error state cleared.

## Timing
- Read latency: 1 cycle after the address phase, zero wait states.
- Write: 0 wait states. The RAM array is updated at the clock edge that ends the data phase.
- Write→read back-to-back: exactly 1 wait state.
- Read→write, read→read, write→write: 0 wait states.
- The address-phase RAM drive is combinational from the AHB inputs. No flop sits between HADDR and RAM_A on the read path.

## Configuration
- AHBL_RAM_ALIGN_ERR_EN defined: misaligned transfers and HSIZE>010 get the standard two-cycle ERROR response, with no RAM access and no wr_pend set.
  - Misaligned means a half with HADDR[0]=1, or a word with HADDR[1:0]≠0.
  - Response: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1.
- AHBL_RAM_ALIGN_ERR_EN undefined: HRESP is tied 0. Misaligned low address bits are forced to alignment: half ignores HADDR[0], word ignores HADDR[1:0]. HSIZE>010 is treated as word.

## Structure
- Shared package: HTRANS encodings, HSIZE encodings, HRESP_OKAY/HRESP_ERROR, and the AW default.
- One sub-module, ahbl_ram_lane_dec, decodes HSIZE and HADDR[1:0] into the 4-bit mask and, under the macro, a misaligned flag.
- The RAM macro is instantiated outside this block.

## Test plan
- Reset mid-write: assert HRESETn=0 during a write data phase → RAM_WE=0 immediately, HREADYOUT=1, HRESP=0. A subsequent read of that address returns the old value.
- Word write 0xDEADBEEF to 0x0000_0010, IDLE, then read 0x10 → HRDATA=0xDEADBEEF, zero wait states on both transfers.
- Byte write 0xAA to 0x13 over 0x11223344 at word 4 → RAM_WE=4'b1000; read back gives 0xAA223344. Half write 0x5566 to 0x12 gives 0x55663344.
- Write 0x12345678 to 0x20 immediately followed by a read of 0x20 → one HREADYOUT=0 cycle, then HRDATA=0x12345678.
- Back-to-back word writes to 0x0, 0x4, 0x8, then three reads → HREADYOUT=1 throughout the writes, one wait state at the write→read turn, data in order.
- With AHBL_RAM_ALIGN_ERR_EN, a word write to 0x2 → HRESP=1 with HREADYOUT 0 then 1, RAM_EN stays 0. Without the macro, the same write lands at word 0.

Source files
------------

// File: rtl/ahbl_ram_ctrl_pkg.sv
// Shared encodings for the AHB-Lite RAM controller: transfer types, sizes,
// responses and the default RAM word-address width.
package ahbl_ram_ctrl_pkg;

  localparam int AW_DEF = 12;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahbl_ram_ctrl_if.sv
// AHB-Lite subordinate port plus the single-port RAM macro port, bundled so
// the controller, interconnect and RAM wrapper share one connection.
interface ahbl_ram_ctrl_if
  import ahbl_ram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic          RAM_EN;
  logic [3:0]    RAM_WE;
  logic [AW-1:0] RAM_A;
  logic [31:0]   RAM_DI;
  logic [31:0]   RAM_DO;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, RAM_DO,
    output HREADYOUT, HRESP, HRDATA, RAM_EN, RAM_WE, RAM_A, RAM_DI
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, RAM_DO,
    input  HREADYOUT, HRESP, HRDATA, RAM_EN, RAM_WE, RAM_A, RAM_DI
  );
endinterface

// File: rtl/ahbl_ram_lane_dec.sv
// Byte-lane decoder: HSIZE and HADDR[1:0] to a RAM write mask.
// With AHBL_RAM_ALIGN_ERR_EN it also flags misaligned or oversized transfers.
module ahbl_ram_lane_dec
  import ahbl_ram_ctrl_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
`ifdef AHBL_RAM_ALIGN_ERR_EN
  output logic       misalign,
`endif
  output logic [3:0] mask
);

  // Sizes above word fall into the default arm and are treated as word.
  always_comb begin
    mask = 4'b1111;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: mask = 4'b0011 << {addr_lo[1], 1'b0};
      default:    mask = 4'b1111;
    endcase
  end

`ifdef AHBL_RAM_ALIGN_ERR_EN
  always_comb begin
    misalign = ((size == HSIZE_HALF) && addr_lo[0])
            || ((size == HSIZE_WORD) && (addr_lo != 2'b00))
            || (size > HSIZE_WORD);
  end
`endif

endmodule

// File: rtl/ahbl_ram_ctrl.sv
// AHB-Lite to single-port synchronous RAM bridge: zero-wait reads, writes
// committed in their data phase, one wait state on write->read turnaround.
// Build option AHBL_RAM_ALIGN_ERR_EN: ERROR response on misaligned/oversized transfers.
module ahbl_ram_ctrl
  import ahbl_ram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
)(
  input  logic           HCLK,
  input  logic           HRESETn,
  ahbl_ram_ctrl_if.slave bus
);

  logic          accept;
  logic          err_req;
  logic          wr_req;
  logic          rd_issue;
  logic          collide;
  logic [3:0]    mask;
  logic [AW-1:0] haddr_word;
  logic          wr_pend;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_mask;
  logic          unused_bits;

  assign haddr_word  = bus.HADDR[AW+1:2];
  assign unused_bits = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};
  assign accept      = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

`ifdef AHBL_RAM_ALIGN_ERR_EN
  logic misalign;

  ahbl_ram_lane_dec u_lane_dec (
    .size     (bus.HSIZE),
    .addr_lo  (bus.HADDR[1:0]),
    .misalign (misalign),
    .mask     (mask)
  );

  assign err_req = accept & misalign;
`else
  ahbl_ram_lane_dec u_lane_dec (
    .size    (bus.HSIZE),
    .addr_lo (bus.HADDR[1:0]),
    .mask    (mask)
  );

  assign err_req = 1'b0;
`endif

  assign wr_req   = accept & bus.HWRITE & ~err_req;
  assign rd_issue = accept & ~bus.HWRITE & ~err_req & ~wr_pend & HRESETn;
  // Read address phase arriving during a write data phase: the write owns the
  // RAM port this cycle, so stall and let the read issue next cycle.
  assign collide  = wr_pend & bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_mask <= '0;
    end else begin
      wr_pend <= wr_req;
      if (wr_req) begin
        wr_addr <= haddr_word;
        wr_mask <= mask;
      end
    end
  end

  assign bus.RAM_EN = wr_pend | rd_issue;
  assign bus.RAM_WE = wr_pend ? wr_mask : 4'b0000;
  assign bus.RAM_A  = wr_pend ? wr_addr : haddr_word;
  assign bus.RAM_DI = wr_pend ? bus.HWDATA : 32'h0;
  assign bus.HRDATA = bus.RAM_DO;

`ifdef AHBL_RAM_ALIGN_ERR_EN
  // state    | meaning
  // ST_OK    | normal operation, OKAY response
  // ST_ERR1  | first ERROR cycle, HREADYOUT low
  // ST_ERR2  | second ERROR cycle, HREADYOUT high
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [1:0] err_st;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_st <= ST_OK;
    end else if (err_req) begin
      err_st <= ST_ERR1;
    end else if (err_st == ST_ERR1) begin
      err_st <= ST_ERR2;
    end else begin
      err_st <= ST_OK;
    end
  end

  assign bus.HRESP     = (err_st != ST_OK) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HREADYOUT = ~collide & (err_st != ST_ERR1);
`else
  assign bus.HRESP     = HRESP_OKAY;
  assign bus.HREADYOUT = ~collide;
`endif

endmodule

// File: tb/tb_ahbl_ram_ctrl.sv
// Directed bench for ahbl_ram_ctrl with a behavioural RAM and a scoreboard
// monitor that checks every completed data phase.
module tb_ahbl_ram_ctrl;
  import ahbl_ram_ctrl_pkg::*;

  localparam int AW = AW_DEF;

  logic HCLK;
  logic HRESETn;

  ahbl_ram_ctrl_if #(.AW(AW)) bus ();

  ahbl_ram_ctrl #(.AW(AW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  assign bus.HREADY = bus.HREADYOUT;

  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge HCLK) begin
    if (bus.RAM_EN) begin
      for (int b = 0; b < 4; b++)
        if (bus.RAM_WE[b]) mem[bus.RAM_A][8*b +: 8] <= bus.RAM_DI[8*b +: 8];
      bus.RAM_DO <= (bus.RAM_WE == 4'b0000) ? mem[bus.RAM_A] : 32'h0;
    end else begin
      bus.RAM_DO <= 32'h0;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic dp_valid = 1'b0;
  int   waits    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: tracks data phases from the bus and pops one expectation per completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_valid = 1'b0;
      end else begin
        if (dp_valid) begin
          if (bus.HREADYOUT) begin
            if (sbq.size() == 0) begin
              n_total++;
              $display("FAIL sb_unexpected: data phase completed with empty queue at %0t", $time);
            end else begin
              e = sbq.pop_front();
              if (!e.wr) chk("rdata", bus.HRDATA, e.rdata);
              chk("hresp", {31'h0, bus.HRESP}, {31'h0, e.resp});
              chk("waits", waits, e.waits);
            end
            dp_valid = 1'b0;
          end else begin
            waits++;
          end
        end
        if (bus.HSEL && bus.HTRANS[1] && bus.HREADYOUT) begin
          dp_valid = 1'b1;
          waits    = 0;
        end
      end
    end
  end

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus_idle();
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Drives one address phase (called at posedge+1), waits for acceptance,
  // then presents write data for its data phase and returns at posedge+1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input int exp_waits, input logic exp_resp);
    exp_t e;
    int   n;
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    e.wr = wr; e.rdata = exp_rd; e.resp = exp_resp; e.waits = exp_waits;
    sbq.push_back(e);
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!bus.HREADYOUT && n < 20);
    if (n >= 20) begin
      n_total++;
      $display("FAIL accept_timeout: addr 0x%08h not accepted within 20 cycles", addr);
    end
    @(posedge HCLK);
    #1;
    if (wr) bus.HWDATA = wdata;
    bus_idle();
  endtask

  initial begin
    int n;
    HRESETn     = 1'b0;
    bus.HSEL    = 1'b0;
    bus.HADDR   = 32'h0;
    bus.HTRANS  = HTRANS_IDLE;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = HSIZE_WORD;
    bus.HWDATA  = 32'h0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    chk("rst_hresp",     {31'h0, bus.HRESP},     32'h0);
    chk("rst_ram_en",    {31'h0, bus.RAM_EN},    32'h0);
    chk("rst_ram_we",    {28'h0, bus.RAM_WE},    32'h0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle_cycles(2);

    // Reset during a write data phase drops the write.
    xfer(1'b1, 32'h40, HSIZE_WORD, 32'hCAFE_0001, 32'h0, 0, 1'b0);
    idle_cycles(1);
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1;
    bus.HADDR = 32'h40; bus.HSIZE = HSIZE_WORD;
    @(negedge HCLK);
    @(posedge HCLK);
    #1;
    bus.HWDATA = 32'hBAD0_BAD0;
    bus_idle();
    chk("wr_dphase_we", {28'h0, bus.RAM_WE}, 32'hF);
    #1 HRESETn = 1'b0;
    #1;
    chk("midrst_ram_we",    {28'h0, bus.RAM_WE},    32'h0);
    chk("midrst_ram_en",    {31'h0, bus.RAM_EN},    32'h0);
    chk("midrst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    chk("midrst_hresp",     {31'h0, bus.HRESP},     32'h0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle_cycles(1);
    xfer(1'b0, 32'h40, HSIZE_WORD, 32'h0, 32'hCAFE_0001, 0, 1'b0);
    idle_cycles(1);

    // Word write, idle, read back.
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    idle_cycles(1);
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    idle_cycles(1);

    // BUSY is not a RAM access.
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_BUSY; bus.HADDR = 32'h10; bus.HWRITE = 1'b0;
    #1 chk("busy_ram_en", {31'h0, bus.RAM_EN}, 32'h0);
    idle_cycles(1);

    // Byte and half writes into word 4.
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'h1122_3344, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h13, HSIZE_BYTE, 32'hAA00_0000, 32'h0, 0, 1'b0);
    #1 chk("byte_ram_we", {28'h0, bus.RAM_WE}, 32'h8);
    idle_cycles(1);
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'hAA22_3344, 0, 1'b0);
    idle_cycles(1);
    xfer(1'b1, 32'h12, HSIZE_HALF, 32'h5566_0000, 32'h0, 0, 1'b0);
    #1 chk("half_ram_we", {28'h0, bus.RAM_WE}, 32'hC);
    idle_cycles(1);
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'h5566_3344, 0, 1'b0);
    idle_cycles(1);

    // Write immediately followed by a read of the same word: one wait state.
    xfer(1'b1, 32'h20, HSIZE_WORD, 32'h1234_5678, 32'h0, 1, 1'b0);
    xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, 32'h1234_5678, 0, 1'b0);
    idle_cycles(1);

    // Three back-to-back writes then three reads.
    xfer(1'b1, 32'h0, HSIZE_WORD, 32'h1111_0000, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h4, HSIZE_WORD, 32'h2222_0001, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h8, HSIZE_WORD, 32'h3333_0002, 32'h0, 1, 1'b0);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, 32'h1111_0000, 0, 1'b0);
    xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, 32'h2222_0001, 0, 1'b0);
    xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, 32'h3333_0002, 0, 1'b0);
    idle_cycles(1);

    // Misaligned word write to 0x2.
`ifdef AHBL_RAM_ALIGN_ERR_EN
    xfer(1'b1, 32'h2, HSIZE_WORD, 32'h7777_7777, 32'h0, 1, 1'b1);
    #1 chk("misalign_ram_en", {31'h0, bus.RAM_EN}, 32'h0);
    idle_cycles(2);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, 32'h1111_0000, 0, 1'b0);
`else
    xfer(1'b1, 32'h2, HSIZE_WORD, 32'h7777_7777, 32'h0, 0, 1'b0);
    #1 chk("misalign_ram_en", {31'h0, bus.RAM_EN}, 32'h1);
    idle_cycles(2);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, 32'h7777_7777, 0, 1'b0);
`endif
    idle_cycles(1);

    n = 0;
    while ((sbq.size() != 0 || dp_valid) && n < 50) begin
      @(posedge HCLK);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL drain_timeout: %0d expectations left", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
